// File: rtl/tfhe_pu_status_ctrl_if.sv
// Board status controller bus: link/activity/error inputs, LED mode control
// and status outputs. Master drives inputs, the controller is the slave.
interface tfhe_pu_status_ctrl_if #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned NUM_CH   = 4
);
  logic                link_up_i;
  logic [NUM_CH-1:0]   act_i;
  logic [NUM_CH-1:0]   err_i;
  logic                err_clr_i;
  logic [1:0]          mode_i;
  logic [NUM_LEDS-1:0] sw_pattern_i;
  logic [NUM_LEDS-1:0] leds;
  logic                link_stable_o;
  logic [7:0]          link_drops_o;
  logic [NUM_CH-1:0]   err_sticky_o;

  modport master (
    output link_up_i, act_i, err_i, err_clr_i, mode_i, sw_pattern_i,
    input  leds, link_stable_o, link_drops_o, err_sticky_o
  );

  modport slave (
    input  link_up_i, act_i, err_i, err_clr_i, mode_i, sw_pattern_i,
    output leds, link_stable_o, link_drops_o, err_sticky_o
  );
endinterface

// File: rtl/tfhe_pu_status_ctrl.sv
// TFHE PU board status/LED controller: debounced PCIe link with drop counter,
// stretched activity, sticky errors, heartbeat and LED mode multiplexing.
module tfhe_pu_status_ctrl #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned HB_HALF  = 50_000_000,
  parameter int unsigned STRETCH  = 10_000_000,
  parameter int unsigned DEBOUNCE = 1024
) (
  input  logic                clk,
  input  logic                rst,
  tfhe_pu_status_ctrl_if.slave bus
);

  localparam int unsigned HB_W = $clog2(HB_HALF + 1);
  localparam int unsigned ST_W = $clog2(STRETCH + 1);
  localparam int unsigned Q_W  = $clog2(DEBOUNCE + 1);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_HALF - 1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH);
  localparam logic [Q_W-1:0]  Q_LAST  = Q_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    LINK_DOWN,
    LINK_QUAL,
    LINK_UP
  } link_state_e;

  link_state_e                   state_q;
  logic [Q_W-1:0]                q_cnt_q;
  logic [7:0]                    drops_q;
  logic                          stable_q;

  logic [HB_W-1:0]               hb_cnt_q, hb_cnt_d;
  logic                          hb_q, hb_d;
  logic [NUM_CH-1:0][ST_W-1:0]   st_cnt_q, st_cnt_d;
  logic [NUM_CH-1:0]             err_q, err_d;
  logic [NUM_CH-1:0]             act_on;
  logic [NUM_LEDS-1:0]           status;
  logic [NUM_LEDS-1:0]           leds_q, leds_d;

  // Link qualification FSM; stable flag is registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LINK_DOWN;
      q_cnt_q  <= '0;
      drops_q  <= '0;
      stable_q <= 1'b0;
    end else begin
      unique case (state_q)
        LINK_DOWN: begin
          if (bus.link_up_i) begin
            state_q <= LINK_QUAL;
            q_cnt_q <= Q_W'(1);
          end
        end
        LINK_QUAL: begin
          if (!bus.link_up_i) begin
            state_q <= LINK_DOWN;
          end else if (q_cnt_q == Q_LAST) begin
            state_q  <= LINK_UP;
            stable_q <= 1'b1;
          end else begin
            q_cnt_q <= q_cnt_q + Q_W'(1);
          end
        end
        LINK_UP: begin
          if (!bus.link_up_i) begin
            state_q  <= LINK_DOWN;
            stable_q <= 1'b0;
            if (drops_q != '1) drops_q <= drops_q + 8'd1;
          end
        end
        default: begin
          state_q  <= LINK_DOWN;
          stable_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    hb_cnt_d = hb_cnt_q + HB_W'(1);
    hb_d     = hb_q;
    if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end

    st_cnt_d = st_cnt_q;
    act_on   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (bus.act_i[c]) st_cnt_d[c] = ST_LOAD;
      else if (st_cnt_q[c] != '0) st_cnt_d[c] = st_cnt_q[c] - ST_W'(1);
      act_on[c] = (st_cnt_q[c] != '0);
    end

    // Clear drops the old flags but a same-cycle error still lands.
    err_d = bus.err_clr_i ? bus.err_i : (err_q | bus.err_i);

    status               = '0;
    status[0]            = hb_q;
    status[1]            = stable_q;
    status[2 +: NUM_CH]  = act_on;
    status[NUM_CH + 2]   = (|err_q) & hb_q;

    leds_d = status;
    unique case (bus.mode_i)
      2'd0:    leds_d = status;
      2'd1:    leds_d = '1;
      2'd2:    leds_d = '0;
      default: leds_d = bus.sw_pattern_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
      st_cnt_q <= '0;
      err_q    <= '0;
      leds_q   <= '0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
      st_cnt_q <= st_cnt_d;
      err_q    <= err_d;
      leds_q   <= leds_d;
    end
  end

  assign bus.leds          = leds_q;
  assign bus.link_stable_o = stable_q;
  assign bus.link_drops_o  = drops_q;
  assign bus.err_sticky_o  = err_q;

endmodule

// File: tb/tb_tfhe_pu_status_ctrl.sv
// Bench for tfhe_pu_status_ctrl: directed scenarios plus random traffic, checked
// every cycle against an edge-count based model of the status rules.
module tb_tfhe_pu_status_ctrl;

  localparam int NUM_LEDS = 8;
  localparam int NUM_CH   = 4;
  localparam int HB_HALF  = 4;
  localparam int STRETCH  = 5;
  localparam int DEBOUNCE = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tfhe_pu_status_ctrl_if #(.NUM_LEDS(NUM_LEDS), .NUM_CH(NUM_CH)) bus ();

  tfhe_pu_status_ctrl #(
    .NUM_LEDS(NUM_LEDS),
    .NUM_CH  (NUM_CH),
    .HB_HALF (HB_HALF),
    .STRETCH (STRETCH),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state described by edges since reset, length of the current
  // link-high run, edge index of each channel's latest pulse, and flags.
  int               m_n;
  int               m_run;
  int               m_drops;
  int               m_last [NUM_CH];
  logic [NUM_CH-1:0] m_err;
  logic [NUM_LEDS-1:0] m_img;
  logic [NUM_LEDS-1:0] exp_leds;

  function automatic logic [NUM_LEDS-1:0] model_image();
    logic [NUM_LEDS-1:0] img;
    logic hb;
    img = '0;
    hb  = ((m_n / HB_HALF) % 2) == 1;
    img[0] = hb;
    img[1] = (m_run >= DEBOUNCE);
    for (int c = 0; c < NUM_CH; c++)
      img[2 + c] = (m_n - m_last[c]) < STRETCH;
    img[NUM_CH + 2] = (m_err != '0) && hb;
    return img;
  endfunction

  task automatic model_reset();
    m_n = 0; m_run = 0; m_drops = 0; m_err = '0; m_img = '0;
    for (int c = 0; c < NUM_CH; c++) m_last[c] = -100;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
      exp_leds = '0;
    end else begin
      case (bus.mode_i)
        2'd0: exp_leds = m_img;
        2'd1: exp_leds = 8'hFF;
        2'd2: exp_leds = 8'h00;
        default: exp_leds = bus.sw_pattern_i;
      endcase
      m_n++;
      if (m_run >= DEBOUNCE && !bus.link_up_i && m_drops < 255) m_drops++;
      if (bus.link_up_i) begin
        if (m_run < 1_000_000) m_run++;
      end else begin
        m_run = 0;
      end
      for (int c = 0; c < NUM_CH; c++)
        if (bus.act_i[c]) m_last[c] = m_n;
      m_err = (bus.err_clr_i ? '0 : m_err) | bus.err_i;
      m_img = model_image();
    end
    #1;
    chk("leds", 32'(bus.leds), 32'(exp_leds));
    chk("link_stable", 32'(bus.link_stable_o), 32'(m_run >= DEBOUNCE));
    chk("link_drops", 32'(bus.link_drops_o), 32'(m_drops));
    chk("err_sticky", 32'(bus.err_sticky_o), 32'(m_err));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    bus.link_up_i    = 1'b0;
    bus.act_i        = '0;
    bus.err_i        = '0;
    bus.err_clr_i    = 1'b0;
    bus.mode_i       = 2'd0;
    bus.sw_pattern_i = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // Heartbeat after reset release
    tick(4);
    chk("t1_leds_4", 32'(bus.leds), 32'h00);
    tick(1);
    chk("t1_leds_5", 32'(bus.leds), 32'h01);
    tick(4);
    chk("t1_leds_9", 32'(bus.leds), 32'h00);

    // Debounce: interrupted run of 7, then a full run of 8
    bus.link_up_i = 1'b1;
    tick(7);
    chk("t2_short_run", 32'(bus.link_stable_o), 32'd0);
    bus.link_up_i = 1'b0;
    tick(1);
    bus.link_up_i = 1'b1;
    tick(7);
    chk("t2_seven", 32'(bus.link_stable_o), 32'd0);
    tick(1);
    chk("t2_eight", 32'(bus.link_stable_o), 32'd1);
    chk("t2_drops", 32'(bus.link_drops_o), 32'd0);

    // Drop counting with saturation
    for (int i = 0; i < 300; i++) begin
      bus.link_up_i = 1'b0;
      tick(1);
      chk("t3_drops", 32'(bus.link_drops_o), 32'((i + 1 > 255) ? 255 : i + 1));
      bus.link_up_i = 1'b1;
      tick(DEBOUNCE);
    end
    chk("t3_saturated", 32'(bus.link_drops_o), 32'd255);

    // Activity stretch with retrigger on channel 2
    bus.act_i = 4'b0100;
    tick(1);
    bus.act_i = '0;
    tick(2);
    bus.act_i = 4'b0100;
    tick(1);
    bus.act_i = '0;
    tick(5);
    chk("t4_still_on", 32'(bus.leds[4]), 32'd1);
    tick(1);
    chk("t4_expired", 32'(bus.leds[4]), 32'd0);

    // Sticky error: set wins over clear, then clear alone
    bus.err_i = 4'b0010;
    bus.err_clr_i = 1'b1;
    tick(1);
    chk("t5_set_wins", 32'(bus.err_sticky_o), 32'h2);
    bus.err_i = '0;
    bus.err_clr_i = 1'b0;
    tick(8);
    bus.err_clr_i = 1'b1;
    tick(1);
    chk("t5_cleared", 32'(bus.err_sticky_o), 32'h0);
    bus.err_clr_i = 1'b0;
    tick(4);

    // LED modes
    bus.mode_i = 2'd1;
    tick(1);
    chk("t6_lamp", 32'(bus.leds), 32'hFF);
    bus.mode_i = 2'd2;
    tick(1);
    chk("t6_off", 32'(bus.leds), 32'h00);
    bus.mode_i = 2'd3;
    bus.sw_pattern_i = 8'hA5;
    tick(1);
    chk("t6_sw", 32'(bus.leds), 32'hA5);
    bus.mode_i = 2'd0;
    tick(8);

    // Asynchronous reset mid-qualification with stretch and sticky active
    bus.link_up_i = 1'b0;
    tick(1);
    bus.link_up_i = 1'b1;
    tick(3);
    bus.act_i = 4'b1111;
    bus.err_i = 4'b1111;
    tick(1);
    bus.act_i = '0;
    bus.err_i = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_leds", 32'(bus.leds), 32'h00);
    chk("rst_stable", 32'(bus.link_stable_o), 32'd0);
    chk("rst_drops", 32'(bus.link_drops_o), 32'd0);
    chk("rst_sticky", 32'(bus.err_sticky_o), 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) bus.link_up_i = ~bus.link_up_i;
      bus.act_i        = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      bus.err_i        = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      bus.err_clr_i    = ($urandom_range(0, 31) == 0);
      bus.mode_i       = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom);
      bus.sw_pattern_i = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
